// File: rtl/button_debounce.sv
// Push-button conditioner: two-flop synchroniser, debounce FSM, event pulses,
// long-press detection and a wrapping press counter.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// IDLE         | released and stable, btn_level = 0
// PRESS_WAIT   | pressed samples seen, qualifying a press
// PRESSED      | press accepted, btn_level = 1, hold timer running
// RELEASE_WAIT | released samples seen, qualifying a release (level still 1)
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int LONG_CYCLES     = 25000000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic [7:0] press_count
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(LONG_CYCLES + 1);

    localparam logic [DW-1:0] DB_ONE    = DW'(1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_LONG = HW'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t        state;
    logic          sync1;
    logic          sync2;
    logic          s;
    logic [DW-1:0] db_cnt;
    logic [HW-1:0] hold_cnt;

    // polarity is applied after the second flop so s is always 1 = pressed
    assign s = ACTIVE_LOW ? ~sync2 : sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            sync1         <= ACTIVE_LOW;
            sync2         <= ACTIVE_LOW;
            db_cnt        <= '0;
            hold_cnt      <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            press_count   <= 8'd0;
        end else begin
            sync1         <= btn_in;
            sync2         <= sync1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;

            // hold timer runs through release qualification so a glitch
            // back to PRESSED cannot re-arm the long-press event
            if (state == PRESSED || state == RELEASE_WAIT) begin
                if (hold_cnt != HOLD_MAX) begin
                    hold_cnt <= hold_cnt + HOLD_ONE;
                end
                if (hold_cnt == HOLD_LONG) begin
                    long_pulse <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (s) begin
                        state  <= PRESS_WAIT;
                        db_cnt <= DB_ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state <= IDLE;
                    end else if (db_cnt == DB_LAST) begin
                        state       <= PRESSED;
                        press_pulse <= 1'b1;
                        btn_level   <= 1'b1;
                        press_count <= press_count + 8'd1;
                        hold_cnt    <= '0;
                    end else begin
                        db_cnt <= db_cnt + DB_ONE;
                    end
                end
                PRESSED: begin
                    if (!s) begin
                        state  <= RELEASE_WAIT;
                        db_cnt <= DB_ONE;
                    end
                end
                RELEASE_WAIT: begin
                    if (s) begin
                        state <= PRESSED;
                    end else if (db_cnt == DB_LAST) begin
                        state         <= IDLE;
                        release_pulse <= 1'b1;
                        btn_level     <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + DB_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
